// File: rtl/fp_mul_round.sv
// fp_mul_round: two-stage normalize/round/pack back end of an FP32 multiplier.
// Ports: CLK, RST (async, active-high); in_valid/in_ready with in_sign,
//   in_exp (10-bit signed biased sum), in_mant (48-bit raw product),
//   in_class (00 norm, 01 zero, 10 inf, 11 NaN); out_valid/out_ready with
//   result (FP32), overflow, underflow, inexact.
// Build option: define FPU_MUL_SUBNORM_EN for gradual underflow, otherwise
//   tiny results flush to signed zero.
module fp_mul_round (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  input  logic [1:0]  in_class,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  localparam logic [1:0] C_ZERO = 2'b01;
  localparam logic [1:0] C_INF  = 2'b10;
  localparam logic [1:0] C_NAN  = 2'b11;

  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // S1 normalize. A normal-class product always has bit 47 or 46 set,
  // so only the 23 fraction bits below the hidden one are carried.
  logic [22:0] w_n_frac;
  logic        w_n_g;
  logic        w_n_s;
  logic [9:0]  w_n_exp;

  always_comb begin
    if (in_mant[47]) begin
      w_n_frac = in_mant[46:24];
      w_n_g    = in_mant[23];
      w_n_s    = |in_mant[22:0];
      w_n_exp  = in_exp + 10'd1;
    end else begin
      w_n_frac = in_mant[45:23];
      w_n_g    = in_mant[22];
      w_n_s    = |in_mant[21:0];
      w_n_exp  = in_exp;
    end
  end

  logic               r_s1_valid;
  logic               r_s1_sign;
  logic [1:0]         r_s1_class;
  logic signed [9:0]  r_s1_exp;
  logic [22:0]        r_s1_frac;
  logic               r_s1_g;
  logic               r_s1_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_class <= 2'b00;
      r_s1_exp   <= '0;
      r_s1_frac  <= '0;
      r_s1_g     <= 1'b0;
      r_s1_s     <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1_sign  <= in_sign;
      r_s1_class <= in_class;
      r_s1_exp   <= w_n_exp;
      r_s1_frac  <= w_n_frac;
      r_s1_g     <= w_n_g;
      r_s1_s     <= w_n_s;
    end
  end

  // S2 round to nearest-even. Carry out of the fraction leaves it zero,
  // which is exactly 0x800000 with the exponent bumped.
  logic              w_inc;
  logic [23:0]       w_sum;
  logic signed [9:0] w_rexp;

  assign w_inc  = r_s1_g & (r_s1_s | r_s1_frac[0]);
  assign w_sum  = {1'b0, r_s1_frac} + {23'd0, w_inc};
  assign w_rexp = r_s1_exp + {9'd0, w_sum[23]};

`ifdef FPU_MUL_SUBNORM_EN
  // Denormalize the pre-round value so it is rounded only once.
  logic signed [9:0] w_dsh;
  logic [4:0]        w_sh;
  logic [49:0]       w_dv;
  logic [23:0]       w_dsig;
  logic              w_dg;
  logic              w_ds;
  logic              w_dinc;
  logic [23:0]       w_dsum;

  assign w_dsh  = 10'sd1 - r_s1_exp;
  assign w_sh   = (w_dsh > 10'sd25) ? 5'd25 : w_dsh[4:0];
  assign w_dv   = {1'b1, r_s1_frac, r_s1_g, 25'd0} >> w_sh;
  assign w_dsig = w_dv[49:26];
  assign w_dg   = w_dv[25];
  assign w_ds   = r_s1_s | (|w_dv[24:0]);
  assign w_dinc = w_dg & (w_ds | w_dsig[0]);
  // Bit 23 of the sum doubles as the exponent field when it rounds up.
  assign w_dsum = w_dsig + {23'd0, w_dinc};
`endif

  logic [31:0] w_res;
  logic        w_ovf;
  logic        w_unf;
  logic        w_inx;

  always_comb begin
    w_res = {r_s1_sign, w_rexp[7:0], w_sum[22:0]};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inx = r_s1_g | r_s1_s;
    if (r_s1_class == C_ZERO) begin
      w_res = {r_s1_sign, 31'd0};
      w_inx = 1'b0;
    end else if (r_s1_class == C_INF) begin
      w_res = {r_s1_sign, 8'hFF, 23'd0};
      w_inx = 1'b0;
    end else if (r_s1_class == C_NAN) begin
      w_res = 32'h7FC0_0000;
      w_inx = 1'b0;
    end else if (w_rexp >= 10'sd255) begin
      w_res = {r_s1_sign, 8'hFF, 23'd0};
      w_ovf = 1'b1;
      w_inx = 1'b1;
    end else if (w_rexp <= 10'sd0) begin
`ifdef FPU_MUL_SUBNORM_EN
      w_res = {r_s1_sign, 7'd0, w_dsum};
      w_inx = w_dg | w_ds;
      w_unf = w_dg | w_ds;
`else
      w_res = {r_s1_sign, 31'd0};
      w_unf = 1'b1;
      w_inx = 1'b1;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      result    <= 32'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_s1_valid;
      result    <= w_res;
      overflow  <= w_ovf;
      underflow <= w_unf;
      inexact   <= w_inx;
    end
  end

endmodule

// File: tb/tb_fp_mul_round.sv
// tb_fp_mul_round: randomized scoreboard bench for fp_mul_round.
// Reference model rounds the raw product with integer remainder arithmetic.
module tb_fp_mul_round;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic [1:0]  in_class;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  fp_mul_round dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp),
    .in_mant(in_mant), .in_class(in_class),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow),
    .underflow(underflow), .inexact(inexact)
  );

  always #5 CLK = ~CLK;

  logic [34:0] sb[$];
  int n_checks = 0;
  int n_err    = 0;
  int n_out    = 0;
  bit rnd      = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Returns {result, overflow, underflow, inexact}.
  function automatic logic [34:0] model(input logic s,
                                        input logic [9:0] ex,
                                        input logic [47:0] mant,
                                        input logic [1:0] cls);
    longint unsigned m, q, rem, half;
    int sh, ep, ef;
    logic up, inx;
    if (cls == 2'b01) return {s, 31'd0, 3'b000};
    if (cls == 2'b10) return {s, 8'hFF, 23'd0, 3'b000};
    if (cls == 2'b11) return {32'h7FC0_0000, 3'b000};
    m    = 64'(mant);
    sh   = mant[47] ? 24 : 23;
    q    = m >> sh;
    rem  = m - (q << sh);
    half = 64'd1 << (sh - 1);
    up   = (rem > half) || (rem == half && q[0]);
    inx  = (rem != 0);
    ep   = int'($signed(ex)) + (mant[47] ? 1 : 0);
    ef   = ep;
    q    = q + 64'(up);
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      ef++;
    end
    if (ef >= 255) return {s, 8'hFF, 23'd0, 3'b101};
    if (ef <= 0) begin
`ifdef FPU_MUL_SUBNORM_EN
      int d;
      d = 1 - ep;
      if (d > 25) d = 25;
      sh   = sh + d;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      up   = (rem > half) || (rem == half && q[0]);
      inx  = (rem != 0);
      q    = q + 64'(up);
      return {s, 8'(q >> 23), q[22:0], 1'b0, inx, inx};
`else
      return {s, 31'd0, 3'b011};
`endif
    end
    return {s, 8'(ef), q[22:0], 2'b00, inx};
  endfunction

  // Expected response enters the queue when a transfer is about to occur.
  always @(negedge CLK) begin
    if (!RST && in_valid && in_ready)
      sb.push_back(model(in_sign, in_exp, in_mant, in_class));
  end

  // Monitor: pops and compares on every output transfer.
  always @(negedge CLK) begin
    logic [34:0] e;
    if (!RST && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_output: got %h, expected none", result);
      end else begin
        e = sb.pop_front();
        chk("sb_result", {result, overflow, underflow, inexact}, e);
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic s, input logic [9:0] e,
                      input logic [47:0] m, input logic [1:0] c);
    bit ok = 1'b0;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_class = c;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0, expected 1");
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  // Single transfer; the accepting edge counts as edge 1.
  task automatic run1(input string nm, input logic s, input logic [9:0] e,
                      input logic [47:0] m, input logic [1:0] c,
                      input logic [34:0] req);
    int edges = 1;
    send(s, e, m, c);
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
      if (out_valid) break;
    end
    chk({nm, "_lat"}, 64'(edges), 64'd2);
    chk(nm, {result, overflow, underflow, inexact}, req);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int n_before;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_class  = 2'b00;
    out_ready = 1'b1;
    RST       = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {overflow, underflow, inexact}, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    run1("req032", 0, 10'd127, 48'h9000_0000_0000, 2'b00,
         {32'h4010_0000, 3'b000});
    run1("tie_even", 0, 10'd127, 48'h4000_0040_0000, 2'b00,
         {32'h3F80_0000, 3'b001});
    run1("tie_up", 0, 10'd127, 48'h4000_00C0_0000, 2'b00,
         {32'h3F80_0002, 3'b001});
    run1("ovf", 0, 10'd254, 48'h8000_0000_0000, 2'b00,
         {32'h7F80_0000, 3'b101});
    run1("nan", 1, 10'd5, 48'h1234_5678_9ABC, 2'b11,
         {32'h7FC0_0000, 3'b000});
    run1("carry", 0, 10'd126, 48'hFFFF_FF80_0000, 2'b00,
         {32'h4000_0000, 3'b001});
    run1("carry_ovf", 1, 10'd253, 48'hFFFF_FF80_0000, 2'b00,
         {32'hFF80_0000, 3'b101});
    run1("max_exp", 0, 10'd253, 48'h8000_0000_0000, 2'b00,
         {32'h7F00_0000, 3'b000});
    run1("min_normal", 0, 10'd0, 48'h8000_0000_0000, 2'b00,
         {32'h0080_0000, 3'b000});
    run1("zero", 1, 10'd100, 48'h8000_0000_0000, 2'b01,
         {32'h8000_0000, 3'b000});
    run1("inf", 0, 10'd100, 48'h8000_0000_0000, 2'b10,
         {32'h7F80_0000, 3'b000});
`ifdef FPU_MUL_SUBNORM_EN
    run1("tiny", 1, 10'h3FB, 48'h8000_0000_0000, 2'b00,
         {32'h8004_0000, 3'b000});
`else
    run1("tiny", 1, 10'h3FB, 48'h8000_0000_0000, 2'b00,
         {32'h8000_0000, 3'b011});
`endif

    // Back-pressure: two accepted, third held off, head result stable.
    out_ready = 1'b0;
    send(0, 10'd127, 48'h9000_0000_0000, 2'b00);
    send(0, 10'd128, 48'h8000_0000_0000, 2'b00);
    in_sign  = 1'b0;
    in_exp   = 10'd127;
    in_mant  = 48'h4000_0000_0000;
    in_class = 2'b00;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_result", result, 32'h4010_0000);
    end
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (in_ready) break;
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #1;

    // Reset with both stages full must discard everything in flight.
    out_ready = 1'b0;
    send(0, 10'd130, 48'h8000_0000_0000, 2'b00);
    send(1, 10'd131, 48'hC000_0000_0000, 2'b00);
    chk("full_before_rst", out_valid, 1);
    RST = 1'b1;
    sb.delete();
    #1;
    chk("rst_flush_valid", out_valid, 0);
    n_before = n_out;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("in_ready_after_rst", in_ready, 1);
    repeat (6) @(negedge CLK);
    chk("no_stale", 64'(n_out - n_before), 0);
    @(posedge CLK);
    #1;

    // Random traffic with random back-pressure.
    rnd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [47:0] m;
      logic [1:0]  c;
      int          ex;
      int          r;
      m = 48'({$urandom(), $urandom()});
      if (m[47:46] == 2'b00) m[46] = 1'b1;
      if ($urandom_range(0, 3) == 0) m[21:0] = '0;
      ex = int'($urandom_range(0, 330)) - 40;
      r  = int'($urandom_range(0, 15));
      c  = (r < 3) ? 2'(r + 1) : 2'b00;
      send(1'($urandom_range(0, 1)), 10'(ex), m, c);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge CLK);
        #1;
      end
    end
    rnd = 1'b0;
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (sb.size() == 0) break;
    end
    chk("drain", 64'(sb.size()), 0);
    repeat (3) @(posedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fp_mul_round.md
FP_MUL_ROUND -- requirements
Module: fp_mul_round

Interface
REQ-001 SHALL have ports: CLK  in  1  clock; all state on rising edge.
REQ-002 SHALL have ports: RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: in_valid  in  1  upstream multiplier core holds a raw product.
REQ-004 SHALL have ports: in_ready  out  1  block accepts input this cycle.
REQ-005 SHALL have ports: in_sign  in  1  product sign (sign1 ^ sign2).
REQ-006 SHALL have ports: in_exp  in  10  signed two's-complement biased exponent sum exp1+exp2-127, no clamping.
REQ-007 SHALL have ports: in_mant  in  48  unsigned product of two 24-bit significands with hidden bits.
REQ-008 SHALL have ports: in_class  in  2  00 normal, 01 zero, 10 infinity, 11 NaN, decoded upstream.
REQ-009 SHALL have ports: out_valid  out  1  result, overflow, underflow and inexact are valid.
REQ-010 SHALL have ports: out_ready  in  1  downstream accepts the result.
REQ-011 SHALL have ports: result  out  32  IEEE-754 single-precision product.
REQ-012 SHALL have ports: overflow, underflow, inexact  out  1 each  sticky-free per-result flags.

Function
REQ-013 SHALL be a two-stage pipeline: S1 normalizes, S2 rounds and packs into the output registers.
REQ-014 SHALL use adv = !out_valid || out_ready, with in_ready = adv (combinational).
- When adv=1: S2 loads S1 and S1 loads the input.
- When adv=0: all state holds and outputs remain stable.
REQ-015 SHALL accept a transfer when in_valid && in_ready, and deliver out_valid exactly 2 rising edges after the accepting edge when out_ready stays 1.
REQ-016 SHALL sustain one result per cycle under continuous out_ready=1.
REQ-017 SHALL normalize in S1 as follows:
- If in_mant[47]=1: significand = in_mant[47:24], guard = bit 23, sticky = |in_mant[22:0], exponent = in_exp+1.
- Otherwise: significand = in_mant[46:23], guard = bit 22, sticky = |in_mant[21:0], exponent = in_exp.
REQ-018 SHALL round in S2 to nearest-even: increment when guard && (sticky || significand LSB); inexact = guard || sticky.
REQ-019 SHALL, on rounding carry-out (significand 0xFFFFFF+1), set the significand to 0x800000 and increment the exponent.
REQ-020 SHALL flag overflow when the final exponent >= 255: result {sign,0xFF,0}, overflow=1, inexact=1.
REQ-021 SHALL handle a final exponent <= 0 per REQ-030/REQ-031.
REQ-022 SHALL handle special classes by bypassing arithmetic, with all flags 0:
- zero -> {sign,31'h0}
- infinity -> {sign,0xFF,23'h0}
- NaN -> 32'h7FC00000
REQ-023 SHALL compute all exponent arithmetic in 10-bit signed width with no wrap for inputs in [-280,+400].

Reset
REQ-024 SHALL, while RST=1, clear S1 and S2 valid bits immediately, including any in-flight data.
REQ-025 SHALL reset outputs to: out_valid=0, result=32'h0, overflow=0, underflow=0, inexact=0.
REQ-026 SHALL drive in_ready=1 one cycle after RST deasserts and accept input on the first edge after deassertion.

Configuration
REQ-027 SHALL use macro FPU_MUL_SUBNORM_EN to select subnormal handling.
REQ-028 SHALL, when FPU_MUL_SUBNORM_EN is defined, denormalize a final exponent <= 0:
- Shift the significand right by 1-exp, saturating at 25.
- OR shifted-out bits into sticky, then round per REQ-018.
- Exponent field = 0, or 1 if rounding reaches 0x800000.
- underflow = inexact.
REQ-029 SHALL, when FPU_MUL_SUBNORM_EN is undefined, flush a final exponent <= 0 to {sign,31'h0} with underflow=1 and inexact=1.
REQ-030 SHALL apply REQ-028 or REQ-029 as the underflow behaviour referenced by REQ-021.
REQ-031 SHALL keep latency and handshake identical in both builds.

Verification
REQ-032 SHALL cover: sign=0, exp=127, mant=48'h9000_0000_0000, class=00 -> result 0x40100000 two cycles later, all flags 0.
REQ-033 SHALL cover: exp=127, mant=48'h4000_0040_0000 -> 0x3F800000 with inexact=1 (tie, round down); mant=48'h4000_00C0_0000 -> 0x3F800002 with inexact=1.
REQ-034 SHALL cover: exp=254, mant=48'h8000_0000_0000 -> 0x7F800000, overflow=1, inexact=1; and class=11 -> 0x7FC00000, flags 0.
REQ-035 SHALL cover: sign=1, exp=-5, normal mant with macro undefined -> 0x80000000, underflow=1.
REQ-036 SHALL cover: three back-to-back inputs with out_ready=0 -> in_ready falls after two accepted inputs, result is stable, and release yields in-order results.
REQ-037 SHALL cover: RST pulse with both stages full -> out_valid=0 the same cycle, and no stale result appears afterwards.
